// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: walks fetch_pc through a combinational instruction memory
// and queues {pc, instruction} pairs for decode behind a valid/ready handshake.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        halted,
  output logic [31:0] delivered_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_HALTED
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [31:0]     r_fetch_pc;
  logic [CW-1:0]   r_count;
  logic [AW-1:0]   r_head;
  logic [AW-1:0]   r_tail;
  logic [31:0]     r_delivered;
  logic [31:0]     r_buf_pc    [DEPTH];
  logic [31:0]     r_buf_instr [DEPTH];

  logic            w_push;
  logic            w_pop;
  logic [31:0]     w_redirect_aligned;

  assign w_redirect_aligned = redirect_pc & 32'hFFFF_FFFC;
  assign w_pop              = out_valid && out_ready;

  // Fetch is gated on the registered occupancy, so a full buffer never fetches
  // even when a pop frees a slot in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    case (r_state)
      ST_BOOT:   w_state_nxt = halt ? ST_HALTED : ST_RUN;
      ST_RUN: begin
        w_push      = (r_count < FULL) && !redirect_valid;
        w_state_nxt = halt ? ST_HALTED : ST_RUN;
      end
      ST_HALTED: w_state_nxt = halt ? ST_HALTED : ST_RUN;
      default:   w_state_nxt = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_BOOT;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc  <= RESET_PC;
      r_count     <= '0;
      r_head      <= '0;
      r_tail      <= '0;
      r_delivered <= '0;
    end else begin
      if (w_pop) r_delivered <= r_delivered + 32'd1;
      if (redirect_valid) begin
        r_fetch_pc <= w_redirect_aligned;
        r_count    <= '0;
        r_head     <= '0;
        r_tail     <= '0;
      end else begin
        if (w_push) begin
          r_tail     <= r_tail + AW'(1);
          r_fetch_pc <= r_fetch_pc + 32'd4;
        end
        if (w_pop) r_head <= r_head + AW'(1);
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  // Buffer storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_buf_pc[r_tail]    <= r_fetch_pc;
      r_buf_instr[r_tail] <= imem_rdata;
    end
  end

  assign imem_addr       = r_fetch_pc;
  assign out_valid       = (r_count != '0);
  assign out_pc          = r_buf_pc[r_head];
  assign out_instr       = r_buf_instr[r_head];
  assign halted          = (r_state == ST_HALTED);
  assign delivered_count = r_delivered;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios followed by a random phase, all
// compared each cycle against a queue-based reference model of the fetch buffer.
module tb_fetch_sequencer;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        halted;
  logic [31:0] delivered_count;

  fetch_sequencer #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt(halt),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc),
    .halted(halted), .delivered_count(delivered_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h003100B3;
    if (a == 32'h4) return 32'h40208233;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  // Reference model: mode 0=boot, 1=run, 2=halted; buffer is a queue of {pc, instr}.
  logic [63:0] m_q[$];
  logic [31:0] m_pc;
  int          m_mode;
  logic [31:0] m_dc;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit do_pop, do_push;
    if (rst) begin
      m_q.delete();
      m_pc   = RESET_PC;
      m_mode = 0;
      m_dc   = 32'd0;
    end else begin
      do_pop  = (m_q.size() > 0) && out_ready;
      do_push = (m_mode == 1) && (m_q.size() < DEPTH) && !redirect_valid;
      if (do_pop) begin
        m_dc = m_dc + 32'd1;
        void'(m_q.pop_front());
      end
      if (redirect_valid) begin
        m_q.delete();
        m_pc = {redirect_pc[31:2], 2'b00};
      end else if (do_push) begin
        m_q.push_back({m_pc, mem_word(m_pc)});
        m_pc = m_pc + 32'd4;
      end
      m_mode = halt ? 2 : 1;
    end
  endtask

  task automatic check_all();
    logic [63:0] head;
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_q.size() != 0});
    if (m_q.size() != 0) begin
      head = m_q[0];
      chk("out_pc", out_pc, head[63:32]);
      chk("out_instr", out_instr, head[31:0]);
    end
    chk("imem_addr", imem_addr, m_pc);
    chk("halted", {31'd0, halted}, {31'd0, m_mode == 2});
    chk("delivered_count", delivered_count, m_dc);
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    logic [31:0] dc0;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; halt = 1'b0; out_ready = 1'b1;
    m_pc = RESET_PC; m_mode = 0; m_dc = 0;

    // Reset and boot
    step(); step();
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_dcount", delivered_count, 32'd0);
    rst = 1'b0;
    step();
    chk("boot_e0_valid", {31'd0, out_valid}, 32'd0);
    step();
    chk("boot_e1_valid", {31'd0, out_valid}, 32'd1);
    chk("boot_pc0", out_pc, 32'h0);
    chk("boot_instr0", out_instr, 32'h003100B3);
    out_ready = 1'b0;
    #1;
    chk("no_comb_ready_path", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    step();
    chk("boot_pc1", out_pc, 32'h4);
    chk("boot_instr1", out_instr, 32'h40208233);
    step();
    chk("boot_dcount2", delivered_count, 32'd2);

    // Backpressure from a fresh reset
    rst = 1'b1; step(); rst = 1'b0;
    out_ready = 1'b0;
    repeat (7) step();
    chk("bp_addr_hold", imem_addr, 32'h8);
    chk("bp_head", out_pc, 32'h0);
    out_ready = 1'b1;
    step();
    chk("bp_rel_pc4", out_pc, 32'h4);
    step();
    chk("bp_rel_pc8", out_pc, 32'h8);
    step();

    // Redirect while full, with a handshake in the same cycle
    out_ready = 1'b0;
    repeat (3) step();
    out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0013;
    dc0 = m_dc;
    step();
    chk("redir_valid", {31'd0, out_valid}, 32'd0);
    chk("redir_addr", imem_addr, 32'h10);
    chk("redir_dcount", delivered_count, dc0 + 32'd1);
    redirect_valid = 1'b0;
    step();
    chk("redir_first_pc", out_pc, 32'h10);

    // Halt at fetch_pc 0x20
    redirect_valid = 1'b1; redirect_pc = 32'h20;
    step();
    redirect_valid = 1'b0; halt = 1'b1;
    step();
    chk("halt_flag", {31'd0, halted}, 32'd1);
    chk("halt_addr", imem_addr, 32'h24);
    chk("halt_last_pc", out_pc, 32'h20);
    repeat (3) step();
    chk("halt_frozen", imem_addr, 32'h24);
    chk("halt_drained", {31'd0, out_valid}, 32'd0);
    halt = 1'b0;
    step(); step();
    chk("halt_resume_pc", out_pc, 32'h24);

    // Wrap-around of the fetch PC
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    step();
    redirect_valid = 1'b0;
    step();
    chk("wrap_pc0", out_pc, 32'hFFFF_FFF8);
    step();
    chk("wrap_pc1", out_pc, 32'hFFFF_FFFC);
    step();
    chk("wrap_pc2", out_pc, 32'h0);

    // Mid-stream reset
    rst = 1'b1;
    step();
    chk("mrst_valid", {31'd0, out_valid}, 32'd0);
    chk("mrst_addr", imem_addr, RESET_PC);
    chk("mrst_dcount", delivered_count, 32'd0);
    chk("mrst_halted", {31'd0, halted}, 32'd0);
    rst = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      rst            = ($urandom_range(0, 99) == 0);
      redirect_valid = ($urandom_range(0, 14) == 0);
      redirect_pc    = $urandom_range(0, 1) ? $urandom : (32'hFFFF_FFF0 | $urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) halt = ~halt;
      out_ready      = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
